// File: rtl/rename_unit_pkg.sv
// Shared widths and bundle types for the register-rename stage.
// Default sizing: 32 architectural registers renamed onto 64 physical tags.
package rename_pkg;

    localparam int AREG_WIDTH = 5;
    localparam int PREG_WIDTH = 6;
    localparam int NUM_AREGS  = 1 << AREG_WIDTH;
    localparam int NUM_PREGS  = 1 << PREG_WIDTH;

    typedef logic [AREG_WIDTH-1:0] areg_t;
    typedef logic [PREG_WIDTH-1:0] preg_t;
    typedef logic [PREG_WIDTH:0]   count_t;

    typedef struct packed {
        logic  reg_write;
        preg_t rrd;
        preg_t rrs1;
        preg_t rrs2;
        preg_t old_rrd;
    } renamed_t;

    typedef struct packed {
        logic  valid;
        logic  reg_write;
        areg_t rd;
        preg_t rrd;
        preg_t old_rrd;
    } commit_t;

endpackage

// File: rtl/rename_unit_if.sv
// Decode-side, dispatch-side and ROB-commit signals of the rename stage.
// slave: the rename unit's view; master: the driver (decode/dispatch/ROB).
interface rename_unit_if;
    import rename_pkg::*;

    logic  in_valid;
    logic  in_ready;
    logic  in_reg_write;
    areg_t in_rd;
    areg_t in_rs1;
    areg_t in_rs2;

    logic  out_valid;
    logic  out_ready;
    logic  out_reg_write;
    preg_t out_rrd;
    preg_t out_rrs1;
    preg_t out_rrs2;
    preg_t out_old_rrd;

    logic  commit_valid;
    logic  commit_reg_write;
    areg_t commit_rd;
    preg_t commit_rrd;
    preg_t commit_old_rrd;

    modport slave (
        input  in_valid, in_reg_write, in_rd, in_rs1, in_rs2,
        output in_ready,
        output out_valid, out_reg_write, out_rrd,
        output out_rrs1, out_rrs2, out_old_rrd,
        input  out_ready,
        input  commit_valid, commit_reg_write, commit_rd,
        input  commit_rrd, commit_old_rrd
    );

    modport master (
        output in_valid, in_reg_write, in_rd, in_rs1, in_rs2,
        input  in_ready,
        input  out_valid, out_reg_write, out_rrd,
        input  out_rrs1, out_rrs2, out_old_rrd,
        output out_ready,
        output commit_valid, commit_reg_write, commit_rd,
        output commit_rrd, commit_old_rrd
    );

endinterface

// File: rtl/rename_unit_free_list.sv
// Circular free list of physical tags: pop at head, push at tail, sticky overflow.
// Ports: clk, rst (async active-low), pop, push/push_tag, head_tag, count, overflow_err;
// with RENAME_RECOVERY_EN also flush/commit_alloc and a committed head pointer.
module rename_free_list
    import rename_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
`ifdef RENAME_RECOVERY_EN
    input  logic   flush,
    input  logic   commit_alloc,
`endif
    input  logic   pop,
    input  logic   push,
    input  preg_t  push_tag,
    output preg_t  head_tag,
    output count_t count,
    output logic   overflow_err
);

    preg_t mem [NUM_PREGS];
    preg_t head;
    preg_t tail;
    logic  full;
    logic  push_ok;
    preg_t tail_next;

    assign full      = (count == count_t'(NUM_PREGS));
    assign push_ok   = push & ~full;
    assign head_tag  = mem[head];
    assign tail_next = tail + preg_t'(push_ok);

`ifdef RENAME_RECOVERY_EN
    // Committed head: tags popped by instructions that have retired.
    preg_t ch;
    preg_t ch_next;

    assign ch_next = ch + preg_t'(commit_alloc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ch <= '0;
        else      ch <= ch_next;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                if (i < NUM_PREGS - NUM_AREGS) mem[i] <= preg_t'(NUM_AREGS + i);
                else                           mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[tail] <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head         <= '0;
            tail         <= preg_t'(NUM_PREGS - NUM_AREGS);
            count        <= count_t'(NUM_PREGS - NUM_AREGS);
            overflow_err <= 1'b0;
        end else begin
            tail <= tail_next;
            if (push & full) overflow_err <= 1'b1;
`ifdef RENAME_RECOVERY_EN
            if (flush) begin
                // Everything between committed head and tail is free again.
                head  <= ch_next;
                count <= {1'b0, tail_next - ch_next};
            end else begin
                head  <= head + preg_t'(pop);
                count <= count + count_t'(push_ok) - count_t'(pop);
            end
`else
            head  <= head + preg_t'(pop);
            count <= count + count_t'(push_ok) - count_t'(pop);
`endif
        end
    end

endmodule

// File: rtl/rename_unit.sv
// Register rename stage: speculative RAT, free list, registered output with handshake.
// Ports: clk, rst (async active-low), bus (rename_unit_if.slave), free_count, overflow_err;
// macro RENAME_RECOVERY_EN adds flush input and a committed RAT for recovery.
module rename_unit
    import rename_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    rename_unit_if.slave  bus,
`ifdef RENAME_RECOVERY_EN
    input  logic          flush,
`endif
    output count_t        free_count,
    output logic          overflow_err
);

    preg_t    rat [NUM_AREGS];
    renamed_t out_q;
    renamed_t ren_d;
    commit_t  cm;
    logic     out_valid;
    logic     alloc;
    logic     in_ready;
    logic     fire;
    logic     push;
    logic     commit_alloc;
    logic     flush_w;
    preg_t    head_tag;

    assign cm = '{
        valid:     bus.commit_valid,
        reg_write: bus.commit_reg_write,
        rd:        bus.commit_rd,
        rrd:       bus.commit_rrd,
        old_rrd:   bus.commit_old_rrd
    };

    assign commit_alloc = cm.valid & cm.reg_write & (cm.rd != '0);
    assign push = cm.valid & cm.reg_write & (cm.old_rrd != '0);

`ifdef RENAME_RECOVERY_EN
    assign flush_w = flush;
`else
    logic unused_commit;
    assign flush_w = 1'b0;
    assign unused_commit = ^{commit_alloc, cm.rrd};
`endif

    // x0 never allocates, so preg 0 stays pinned to it.
    assign alloc = bus.in_reg_write & (bus.in_rd != '0);

    // free_count is pre-push: a same-cycle commit cannot unblock rename.
    assign in_ready = (~out_valid | bus.out_ready)
                    & (~alloc | (free_count != '0))
                    & ~flush_w;
    assign fire = bus.in_valid & in_ready;

    always_comb begin
        ren_d           = '0;
        ren_d.rrs1      = rat[bus.in_rs1];
        ren_d.rrs2      = rat[bus.in_rs2];
        if (alloc) begin
            ren_d.reg_write = 1'b1;
            ren_d.rrd       = head_tag;
            ren_d.old_rrd   = rat[bus.in_rd];
        end
    end

    rename_free_list u_free_list (
        .clk          (clk),
        .rst          (rst),
`ifdef RENAME_RECOVERY_EN
        .flush        (flush_w),
        .commit_alloc (commit_alloc),
`endif
        .pop          (fire & alloc),
        .push         (push),
        .push_tag     (cm.old_rrd),
        .head_tag     (head_tag),
        .count        (free_count),
        .overflow_err (overflow_err)
    );

`ifdef RENAME_RECOVERY_EN
    preg_t crat [NUM_AREGS];
    preg_t crat_next [NUM_AREGS];

    always_comb begin
        for (int i = 0; i < NUM_AREGS; i++) crat_next[i] = crat[i];
        if (commit_alloc) crat_next[cm.rd] = cm.rrd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_AREGS; i++) crat[i] <= preg_t'(i);
        end else begin
            for (int i = 0; i < NUM_AREGS; i++) crat[i] <= crat_next[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_AREGS; i++) rat[i] <= preg_t'(i);
`ifdef RENAME_RECOVERY_EN
        end else if (flush_w) begin
            // Restore includes this cycle's commit.
            for (int i = 0; i < NUM_AREGS; i++) rat[i] <= crat_next[i];
`endif
        end else if (fire & alloc) begin
            rat[bus.in_rd] <= head_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (flush_w) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_q     <= ren_d;
            out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_reg_write = out_q.reg_write;
    assign bus.out_rrd       = out_q.rrd;
    assign bus.out_rrs1      = out_q.rrs1;
    assign bus.out_rrs2      = out_q.rrs2;
    assign bus.out_old_rrd   = out_q.old_rrd;

endmodule

// File: tb/tb_rename_unit.sv
// Directed self-checking bench for rename_unit.
// Covers renaming, x0, drain/refill, stall, push+pop, overflow, optional flush.
module tb_rename_unit;
    import rename_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    count_t free_count;
    logic   overflow_err;
`ifdef RENAME_RECOVERY_EN
    logic   flush = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rename_unit_if bus ();

    rename_unit dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
`ifdef RENAME_RECOVERY_EN
        .flush        (flush),
`endif
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid         = 1'b0;
        bus.in_reg_write     = 1'b0;
        bus.in_rd            = '0;
        bus.in_rs1           = '0;
        bus.in_rs2           = '0;
        bus.commit_valid     = 1'b0;
        bus.commit_reg_write = 1'b0;
        bus.commit_rd        = '0;
        bus.commit_rrd       = '0;
        bus.commit_old_rrd   = '0;
    endtask

    task automatic do_reset();
        idle();
        bus.out_ready = 1'b1;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic drive(logic rw, int rd, int rs1, int rs2);
        bus.in_valid     = 1'b1;
        bus.in_reg_write = rw;
        bus.in_rd        = areg_t'(rd);
        bus.in_rs1       = areg_t'(rs1);
        bus.in_rs2       = areg_t'(rs2);
    endtask

    task automatic commit(logic rw, int rd, int rrd, int old);
        bus.commit_valid     = 1'b1;
        bus.commit_reg_write = rw;
        bus.commit_rd        = areg_t'(rd);
        bus.commit_rrd       = preg_t'(rrd);
        bus.commit_old_rrd   = preg_t'(old);
    endtask

    task automatic issue(logic rw, int rd, int rs1, int rs2);
        drive(rw, rd, rs1, rs2);
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        idle();
        bus.out_ready = 1'b1;
        step();
        check("rst_count", free_count, 32);
        check("rst_oval", bus.out_valid, 0);
        check("rst_ovf", overflow_err, 0);
        check("rst_rrd", bus.out_rrd, 0);
        rst = 1'b1;
        #1;
        check("rst_ready", bus.in_ready, 1);

        issue(1, 5, 1, 2);
        check("add_oval", bus.out_valid, 1);
        check("add_rrd", bus.out_rrd, 32);
        check("add_old", bus.out_old_rrd, 5);
        check("add_rs1", bus.out_rrs1, 1);
        check("add_rs2", bus.out_rrs2, 2);
        check("add_rw", bus.out_reg_write, 1);
        check("add_count", free_count, 31);
        step();
        check("drain_oval", bus.out_valid, 0);

        do_reset();
        issue(1, 5, 5, 5);
        check("dep1_rrd", bus.out_rrd, 32);
        check("dep1_rs1", bus.out_rrs1, 5);
        check("dep1_rs2", bus.out_rrs2, 5);
        check("dep1_old", bus.out_old_rrd, 5);
        issue(1, 5, 5, 5);
        check("dep2_rrd", bus.out_rrd, 33);
        check("dep2_rs1", bus.out_rrs1, 32);
        check("dep2_old", bus.out_old_rrd, 32);
        check("dep2_count", free_count, 30);

        issue(1, 0, 3, 4);
        check("x0_rw", bus.out_reg_write, 0);
        check("x0_rrd", bus.out_rrd, 0);
        check("x0_old", bus.out_old_rrd, 0);
        check("x0_rs1", bus.out_rrs1, 3);
        check("x0_rs2", bus.out_rrs2, 4);
        check("x0_count", free_count, 30);

        do_reset();
        for (int i = 0; i < 32; i++) begin
            issue(1, (i % 31) + 1, 0, 0);
            check("drain_rrd", bus.out_rrd, 32 + i);
        end
        check("empty_count", free_count, 0);
        drive(1, 9, 1, 0);
        #1;
        check("empty_ready", bus.in_ready, 0);
        commit(1, 7, 38, 7);
        step();
        bus.commit_valid = 1'b0;
        check("empty_nofire", bus.out_rrd, 63);
        check("refill_count", free_count, 1);
        check("refill_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        check("refill_rrd", bus.out_rrd, 7);
        check("refill_old", bus.out_old_rrd, 40);
        check("refill_rs1", bus.out_rrs1, 63);
        check("refill_count0", free_count, 0);

        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_oval", bus.out_valid, 1);
            check("stall_rrd", bus.out_rrd, 7);
            check("stall_old", bus.out_old_rrd, 40);
            check("stall_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        step();
        check("unstall_oval", bus.out_valid, 0);

        commit(1, 8, 39, 8);
        step();
        bus.commit_valid = 1'b0;
        check("pp_pre", free_count, 1);
        drive(1, 10, 0, 0);
        commit(1, 9, 41, 9);
        step();
        idle();
        check("pp_count", free_count, 1);
        check("pp_rrd", bus.out_rrd, 8);
        check("pp_rw", bus.out_reg_write, 1);

        do_reset();
        commit(1, 0, 0, 0);
        step();
        check("zero_nopush", free_count, 32);
        commit(0, 0, 0, 12);
        step();
        check("norw_nopush", free_count, 32);
        for (int i = 0; i < 32; i++) begin
            commit(1, 0, 0, i + 1);
            step();
        end
        idle();
        check("full_count", free_count, 64);
        check("full_ovf", overflow_err, 0);
        commit(1, 0, 0, 5);
        step();
        idle();
        check("ovf_set", overflow_err, 1);
        check("ovf_count", free_count, 64);
        step();
        step();
        step();
        check("ovf_sticky", overflow_err, 1);
        rst = 1'b0;
        #1;
        check("ovf_clear", overflow_err, 0);
        rst = 1'b1;

`ifdef RENAME_RECOVERY_EN
        do_reset();
        issue(1, 3, 0, 0);
        check("rec_rrd3", bus.out_rrd, 32);
        issue(1, 4, 0, 0);
        check("rec_rrd4", bus.out_rrd, 33);
        commit(1, 3, 32, 3);
        step();
        idle();
        check("rec_cnt", free_count, 31);
        flush = 1'b1;
        #1;
        check("rec_ready", bus.in_ready, 0);
        step();
        flush = 1'b0;
        check("rec_oval", bus.out_valid, 0);
        check("rec_count", free_count, 32);
        issue(0, 0, 4, 3);
        check("rec_rat4", bus.out_rrs1, 4);
        check("rec_rat3", bus.out_rrs2, 32);
        issue(1, 5, 0, 0);
        check("rec_head", bus.out_rrd, 33);
        check("rec_old", bus.out_old_rrd, 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Parametrised register-rename stage between decode_buffer and dispatch.
- Replaces the loose Areg_file/free_pool pairing with one block: speculative RAT, circular free list, registered output stage with valid/ready handshake on both sides, and a commit port that returns freed physical registers.
- Single-issue; sizes are parametrised.

Parameters:
AREG_WIDTH, 5, architectural register index width
PREG_WIDTH, 6, physical register tag width
NUM_AREGS, 32, architectural registers (2**AREG_WIDTH)
NUM_PREGS, 64, physical registers (2**PREG_WIDTH); free-list depth = NUM_PREGS

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  rename accepts this cycle
in_reg_write  in  1  instruction writes rd
in_rd  in  AREG_WIDTH  destination arch reg
in_rs1  in  AREG_WIDTH  source 1 arch reg
in_rs2  in  AREG_WIDTH  source 2 arch reg
out_valid  out  1  renamed instruction held
out_ready  in  1  downstream accepts
out_reg_write  out  1  allocation performed
out_rrd  out  PREG_WIDTH  new dest tag
out_rrs1  out  PREG_WIDTH  source 1 tag
out_rrs2  out  PREG_WIDTH  source 2 tag
out_old_rrd  out  PREG_WIDTH  previous mapping of rd (ROB frees it at commit)
commit_valid  in  1  ROB retires an instruction
commit_reg_write  in  1  retiring instruction allocated
commit_rd  in  AREG_WIDTH  retiring rd
commit_rrd  in  PREG_WIDTH  retiring new tag
commit_old_rrd  in  PREG_WIDTH  tag to free
free_count  out  PREG_WIDTH+1  free-list occupancy
overflow_err  out  1  sticky: free push while full

Behaviour:
- Reset (rst=0, async): RAT[i]=i; free list holds tags NUM_AREGS..NUM_PREGS-1 in ascending order; head=0, tail=NUM_PREGS-NUM_AREGS; free_count=32. All out_* = 0; overflow_err=0.
- alloc = in_reg_write & (in_rd!=0).
- in_ready = (!out_valid | out_ready) & (!alloc | free_count!=0). Combinational; free_count is taken before this cycle's push, so there is no same-cycle bypass.
- fire = in_valid & in_ready. On fire, out_* load at the clock edge (latency 1):
  - out_rrs1/2 = RAT[rs] before this instruction's write, so rs==rd returns the old mapping.
  - out_old_rrd = RAT[rd].
  - If alloc: out_rrd = free[head]; head++ (wraps mod NUM_PREGS); RAT[rd] = out_rrd; out_reg_write = 1.
  - Else: out_rrd = 0, out_old_rrd = 0, out_reg_write = 0.
- Arch reg 0 always maps to preg 0 and is never reallocated or freed.
- out_valid set on fire. Cleared when out_ready & !fire. Holds its value with stable out_* while out_ready = 0.
- Back-to-back dependence: the RAT is written at the fire edge, so the next instruction sees the new tag.
- Commit: if commit_valid & commit_reg_write & commit_old_rrd!=0:
  - free[tail] = commit_old_rrd; tail++.
  - If free_count == NUM_PREGS: push dropped and overflow_err set.
- free_count += push - pop. A simultaneous push and pop leaves the count unchanged.
- Pointers are PREG_WIDTH bits and wrap naturally.

Optional Feature:
- Macro RENAME_RECOVERY_EN.
- When defined, adds input `flush` (1 bit), a committed RAT, and a committed head pointer (ch):
  - On commit with commit_reg_write & commit_rd!=0: cRAT[commit_rd] = commit_rrd; ch++.
  - On flush: RAT = cRAT (including that same cycle's commit); head = ch (post-commit); free_count = tail - ch (post-push); out_valid = 0; in_ready = 0; no fire.
  - Reset: cRAT[i]=i, ch=0.
- When undefined: no flush port, no committed state; the commit port only frees tags.

Decomposition:
- Package rename_pkg: AREG_WIDTH, PREG_WIDTH, NUM_AREGS, NUM_PREGS defaults; renamed-instruction struct {reg_write, rrd, rrs1, rrs2, old_rrd}; commit struct.
- One natural sub-module: rename_free_list (circular buffer, head/tail/count, overflow, optional committed head). RAT and output register stay in rename_unit.

Test Plan:
- Reset release -> free_count=32, in_ready=1; first rename of add x5,x1,x2 -> out_rrd=32, out_old_rrd=5, out_rrs1=1, out_rrs2=2.
- Rename add x5,x5,x5 twice -> first: rrd=32, rrs=5, old=5; second: rrd=33, rrs=32, old=32.
- rd=x0 with reg_write=1 -> out_reg_write=0, out_rrd=0, free_count unchanged.
- Drain free list with 32 allocating instructions, then one more -> in_ready=0. Commit old_rrd=7 -> next cycle in_ready=1, rrd=7. Out_ready=0 for 3 cycles -> out_* stable.
- Simultaneous pop and commit push at free_count=1 -> count stays 1. Push at count=64 -> overflow_err=1 and stays until reset.
- (RENAME_RECOVERY_EN) Rename x3->32 and x4->33; commit the first; flush -> RAT[4]=4, RAT[3]=32, head=1, free_count=32, out_valid=0.
